// File: rtl/layer_controller.sv
// rtl/layer_controller.sv - MAC command sequencer for one fully connected MLP layer.
// Walks outputs j and inputs i, one registered MAC/write command per cycle.
module layer_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] num_inputs,
    input  logic [11:0] num_outputs,
    input  logic [11:0] in_base,
    input  logic [11:0] out_base,
    input  logic [15:0] weight_base,
    output logic        busy,
    output logic        done,
    output logic [11:0] neuron_addr,
    output logic [15:0] weight_addr,
    output logic        reset_mult_acc,
    output logic [11:0] out_neuron_addr,
    output logic        write_neuron
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] i_q, i_d;
    logic [11:0] j_q, j_d;
    logic [11:0] n_q, n_d;
    logic [11:0] m_q, m_d;
    logic [11:0] in_base_q, in_base_d;
    logic [11:0] out_base_q, out_base_d;
    logic [15:0] wptr_q, wptr_d;
    logic [11:0] neuron_addr_q, neuron_addr_d;
    logic [11:0] out_addr_q, out_addr_d;
    logic        rst_acc_q, rst_acc_d;
    logic        write_q, write_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            i_q           <= '0;
            j_q           <= '0;
            n_q           <= '0;
            m_q           <= '0;
            in_base_q     <= '0;
            out_base_q    <= '0;
            wptr_q        <= '0;
            neuron_addr_q <= '0;
            out_addr_q    <= '0;
            rst_acc_q     <= 1'b0;
            write_q       <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            i_q           <= i_d;
            j_q           <= j_d;
            n_q           <= n_d;
            m_q           <= m_d;
            in_base_q     <= in_base_d;
            out_base_q    <= out_base_d;
            wptr_q        <= wptr_d;
            neuron_addr_q <= neuron_addr_d;
            out_addr_q    <= out_addr_d;
            rst_acc_q     <= rst_acc_d;
            write_q       <= write_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
        end
    end

    // Registers hold the command being presented this cycle; the next-state
    // logic computes the following command so every output stays registered.
    always_comb begin
        state_d       = state_q;
        i_d           = i_q;
        j_d           = j_q;
        n_d           = n_q;
        m_d           = m_q;
        in_base_d     = in_base_q;
        out_base_d    = out_base_q;
        wptr_d        = wptr_q;
        neuron_addr_d = neuron_addr_q;
        out_addr_d    = out_addr_q;
        rst_acc_d     = 1'b0;
        write_d       = 1'b0;
        done_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    n_d        = num_inputs;
                    m_d        = num_outputs;
                    in_base_d  = in_base;
                    out_base_d = out_base;
                    i_d        = '0;
                    j_d        = '0;
                    if (num_inputs == 12'd0 || num_outputs == 12'd0) begin
                        // done_q stays low so DONE spends one extra cycle
                        state_d = DONE;
                    end else begin
                        state_d       = ACC;
                        wptr_d        = weight_base;
                        neuron_addr_d = in_base;
                        rst_acc_d     = 1'b1;
                    end
                end
            end
            ACC: begin
                if (i_q == n_q - 12'd1) begin
                    state_d    = WRITE;
                    write_d    = 1'b1;
                    out_addr_d = out_base_q + j_q;
                end else begin
                    i_d           = i_q + 12'd1;
                    neuron_addr_d = in_base_q + i_q + 12'd1;
                    wptr_d        = wptr_q + 16'd1;
                end
            end
            WRITE: begin
                if (j_q == m_q - 12'd1) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d       = ACC;
                    j_d           = j_q + 12'd1;
                    i_d           = '0;
                    neuron_addr_d = in_base_q;
                    wptr_d        = wptr_q + 16'd1;
                    rst_acc_d     = 1'b1;
                end
            end
            DONE: begin
                if (done_q) begin
                    state_d = IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign neuron_addr     = neuron_addr_q;
    assign weight_addr     = wptr_q;
    assign reset_mult_acc  = rst_acc_q;
    assign out_neuron_addr = out_addr_q;
    assign write_neuron    = write_q;

endmodule

// File: tb/tb_layer_controller.sv
// tb/tb_layer_controller.sv - table-driven bench for layer_controller.
module tb_layer_controller;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [11:0] num_inputs, num_outputs, in_base, out_base;
    logic [15:0] weight_base;
    logic        busy, done, reset_mult_acc, write_neuron;
    logic [11:0] neuron_addr, out_neuron_addr;
    logic [15:0] weight_addr;

    int checks = 0;
    int errors = 0;

    layer_controller dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .num_inputs     (num_inputs),
        .num_outputs    (num_outputs),
        .in_base        (in_base),
        .out_base       (out_base),
        .weight_base    (weight_base),
        .busy           (busy),
        .done           (done),
        .neuron_addr    (neuron_addr),
        .weight_addr    (weight_addr),
        .reset_mult_acc (reset_mult_acc),
        .out_neuron_addr(out_neuron_addr),
        .write_neuron   (write_neuron)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        s;
        logic [11:0] n, m, ib, ob;
        logic [15:0] wb;
        logic        busy, done;
        logic [11:0] na;
        logic [15:0] wa;
        logic        rm;
        logic [11:0] oa;
        logic        wr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic [11:0] n, input logic [11:0] m,
                                input logic [11:0] ib, input logic [11:0] ob, input logic [15:0] wb,
                                input logic b, input logic d, input logic [11:0] na, input logic [15:0] wa,
                                input logic rm, input logic [11:0] oa, input logic wr);
        vec_t v;
        v.r = r; v.s = s; v.n = n; v.m = m; v.ib = ib; v.ob = ob; v.wb = wb;
        v.busy = b; v.done = d; v.na = na; v.wa = wa; v.rm = rm; v.oa = oa; v.wr = wr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic b, input logic d, input logic [11:0] na,
                              input logic [15:0] wa, input logic rm, input logic [11:0] oa, input logic wr);
        chk({tag, ".busy"}, {15'd0, busy}, {15'd0, b});
        chk({tag, ".done"}, {15'd0, done}, {15'd0, d});
        chk({tag, ".neuron_addr"}, {4'd0, neuron_addr}, {4'd0, na});
        chk({tag, ".weight_addr"}, weight_addr, wa);
        chk({tag, ".reset_mult_acc"}, {15'd0, reset_mult_acc}, {15'd0, rm});
        chk({tag, ".out_neuron_addr"}, {4'd0, out_neuron_addr}, {4'd0, oa});
        chk({tag, ".write_neuron"}, {15'd0, write_neuron}, {15'd0, wr});
        chk({tag, ".rm_wr_exclusive"}, {15'd0, reset_mult_acc & write_neuron}, 16'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_row(input int k);
        reset       = vecs[k].r;
        start       = vecs[k].s;
        num_inputs  = vecs[k].n;
        num_outputs = vecs[k].m;
        in_base     = vecs[k].ib;
        out_base    = vecs[k].ob;
        weight_base = vecs[k].wb;
        step();
        check_outs($sformatf("row%0d", k), vecs[k].busy, vecs[k].done, vecs[k].na, vecs[k].wa,
                   vecs[k].rm, vecs[k].oa, vecs[k].wr);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        num_inputs = '0; num_outputs = '0; in_base = '0; out_base = '0; weight_base = '0;

        // Basic layer N=3, M=2
        vecs.push_back(mk(1,0,0,0,12'h000,12'h000,16'h0000, 0,0,12'h000,16'h0000,0,12'h000,0));
        vecs.push_back(mk(0,1,3,2,12'h010,12'h100,16'h2000, 1,0,12'h010,16'h2000,1,12'h000,0));
        vecs.push_back(mk(0,0,3,2,12'h010,12'h100,16'h2000, 1,0,12'h011,16'h2001,0,12'h000,0));
        vecs.push_back(mk(0,0,3,2,12'h010,12'h100,16'h2000, 1,0,12'h012,16'h2002,0,12'h000,0));
        vecs.push_back(mk(0,0,3,2,12'h010,12'h100,16'h2000, 1,0,12'h012,16'h2002,0,12'h100,1));
        vecs.push_back(mk(0,0,3,2,12'h010,12'h100,16'h2000, 1,0,12'h010,16'h2003,1,12'h100,0));
        vecs.push_back(mk(0,0,3,2,12'h010,12'h100,16'h2000, 1,0,12'h011,16'h2004,0,12'h100,0));
        vecs.push_back(mk(0,0,3,2,12'h010,12'h100,16'h2000, 1,0,12'h012,16'h2005,0,12'h100,0));
        vecs.push_back(mk(0,0,3,2,12'h010,12'h100,16'h2000, 1,0,12'h012,16'h2005,0,12'h101,1));
        vecs.push_back(mk(0,0,3,2,12'h010,12'h100,16'h2000, 1,1,12'h012,16'h2005,0,12'h101,0));
        vecs.push_back(mk(0,0,3,2,12'h010,12'h100,16'h2000, 0,0,12'h012,16'h2005,0,12'h101,0));
        // Wrap, with start re-asserted (different N/M) while busy
        vecs.push_back(mk(0,1,3,1,12'hFFE,12'h055,16'hFFFF, 1,0,12'hFFE,16'hFFFF,1,12'h101,0));
        vecs.push_back(mk(0,1,7,1,12'h111,12'h222,16'h3333, 1,0,12'hFFF,16'h0000,0,12'h101,0));
        vecs.push_back(mk(0,1,7,4,12'h111,12'h222,16'h3333, 1,0,12'h000,16'h0001,0,12'h101,0));
        vecs.push_back(mk(0,1,7,4,12'h111,12'h222,16'h3333, 1,0,12'h000,16'h0001,0,12'h055,1));
        vecs.push_back(mk(0,1,7,4,12'h111,12'h222,16'h3333, 1,1,12'h000,16'h0001,0,12'h055,0));
        vecs.push_back(mk(0,0,7,4,12'h111,12'h222,16'h3333, 0,0,12'h000,16'h0001,0,12'h055,0));
        vecs.push_back(mk(0,0,7,4,12'h111,12'h222,16'h3333, 0,0,12'h000,16'h0001,0,12'h055,0));
        // Zero-size layers: N=0 then M=0
        vecs.push_back(mk(0,1,0,5,12'h123,12'h456,16'h789A, 1,0,12'h000,16'h0001,0,12'h055,0));
        vecs.push_back(mk(0,0,0,5,12'h123,12'h456,16'h789A, 1,1,12'h000,16'h0001,0,12'h055,0));
        vecs.push_back(mk(0,0,0,5,12'h123,12'h456,16'h789A, 0,0,12'h000,16'h0001,0,12'h055,0));
        vecs.push_back(mk(0,1,4,0,12'h123,12'h456,16'h789A, 1,0,12'h000,16'h0001,0,12'h055,0));
        vecs.push_back(mk(0,0,4,0,12'h123,12'h456,16'h789A, 1,1,12'h000,16'h0001,0,12'h055,0));
        vecs.push_back(mk(0,0,4,0,12'h123,12'h456,16'h789A, 0,0,12'h000,16'h0001,0,12'h055,0));

        for (int k = 0; k < vecs.size(); k++) apply_row(k);

        // Reset during the 2nd MAC of output neuron 1
        start = 1'b1; num_inputs = 12'd3; num_outputs = 12'd2;
        in_base = 12'h010; out_base = 12'h100; weight_base = 16'h2000;
        step();
        start = 1'b0;
        for (int c = 0; c < 5; c++) step();
        check_outs("pre_reset", 1, 0, 12'h011, 16'h2004, 0, 12'h100, 0);
        reset = 1'b1;
        step();
        check_outs("reset_mid", 0, 0, 12'h000, 16'h0000, 0, 12'h000, 0);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check_outs($sformatf("post_reset%0d", c), 0, 0, 12'h000, 16'h0000, 0, 12'h000, 0);
        end
        for (int k = 1; k <= 10; k++) apply_row(k);

        // Back-to-back N=1, M=1 with start held high
        start = 1'b1; num_inputs = 12'd1; num_outputs = 12'd1;
        in_base = 12'h0AB; out_base = 12'h0CD; weight_base = 16'h1234;
        for (int c = 0; c < 12; c++) begin
            logic [11:0] oa_mac;
            oa_mac = (c < 4) ? 12'h101 : 12'h0CD;
            step();
            case (c % 4)
                0: check_outs($sformatf("b2b%0d_mac", c), 1, 0, 12'h0AB, 16'h1234, 1, oa_mac, 0);
                1: check_outs($sformatf("b2b%0d_wr", c), 1, 0, 12'h0AB, 16'h1234, 0, 12'h0CD, 1);
                2: check_outs($sformatf("b2b%0d_done", c), 1, 1, 12'h0AB, 16'h1234, 0, 12'h0CD, 0);
                default: check_outs($sformatf("b2b%0d_idle", c), 0, 0, 12'h0AB, 16'h1234, 0, 12'h0CD, 0);
            endcase
        end
        start = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
